// File: rtl/bally_video_pkg.sv
// Shared constants for the BALLY video timing regenerator.
// Defaults reproduce the original emu top-level timing.
package bally_video_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int CE_DIV_DEF      = 16;
  localparam int HB_START_DEF    = 214;
  localparam int HB_END_DEF      = 34;
  localparam int VB_START_DEF    = 255;
  localparam int VB_END_DEF      = 25;
  localparam int LOCK_FRAMES_DEF = 4;
  localparam int SHIFT_W         = 6;

endpackage

// File: rtl/bally_lock_tracker.sv
// Frame-length stability tracker.
// Raises locked after LOCK_FRAMES consecutive matching measurements.
module bally_lock_tracker
  import bally_video_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             upd,
  input  logic             v_sat,
  input  logic [CNT_W-1:0] new_len,
  input  logic [CNT_W-1:0] prev_len,
  output logic             locked
);

  localparam int LC_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOCK_FRAMES);

  logic [LC_W-1:0] lock_ct_q, lock_ct_d;
  logic            locked_q, locked_d;

  always_comb begin
    lock_ct_d = lock_ct_q;
    if (upd) begin
      // a frame whose line counter pinned at max is never trusted
      if ((new_len == prev_len) && !v_sat) begin
        lock_ct_d = (lock_ct_q == LC_MAX) ? LC_MAX : lock_ct_q + LC_W'(1);
      end else begin
        lock_ct_d = '0;
      end
    end
    locked_d = (lock_ct_d == LC_MAX);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lock_ct_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      lock_ct_q <= lock_ct_d;
      locked_q  <= locked_d;
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/bally_video_timing.sv
// Video timing regenerator: pixel divider, h/v counters, blank windows,
// line/frame measurement and lock indication for the BALLY core.
module bally_video_timing
  import bally_video_pkg::*;
#(
  parameter int CE_DIV      = CE_DIV_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int HB_START    = HB_START_DEF,
  parameter int HB_END      = HB_END_DEF,
  parameter int VB_START    = VB_START_DEF,
  parameter int VB_END      = VB_END_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic [SHIFT_W-1:0] h_shift,
  input  logic [SHIFT_W-1:0] v_shift,
  output logic               ce_pix,
  output logic               hsync,
  output logic               vsync,
  output logic               hblank,
  output logic               vblank,
  output logic [CNT_W-1:0]   h_cnt,
  output logic [CNT_W-1:0]   v_cnt,
  output logic [CNT_W-1:0]   line_len,
  output logic [CNT_W-1:0]   frame_lines,
  output logic               locked
);

  localparam int DIV_W = $clog2(CE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_W'(1);
  endfunction

  // two guard bits keep base+shift exact before clamping
  function automatic logic [CNT_W-1:0] bound(
    input logic [CNT_W-1:0]          base,
    input logic signed [SHIFT_W-1:0] sh
  );
    logic signed [CNT_W+1:0] s;
    s = $signed({2'b00, base}) + (CNT_W+2)'(sh);
    if (s[CNT_W+1])   return '0;
    else if (s[CNT_W]) return CNT_MAX;
    else               return s[CNT_W-1:0];
  endfunction

  function automatic logic in_win(
    input logic [CNT_W-1:0] c,
    input logic [CNT_W-1:0] s,
    input logic [CNT_W-1:0] e
  );
    if (s > e) return (c >= s) || (c < e);
    else       return (c >= s) && (c < e);
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic             ce_pix_q, ce_pix_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             hblank_q, hblank_d;
  logic             vblank_q, vblank_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [CNT_W-1:0] line_len_q, line_len_d;
  logic [CNT_W-1:0] frame_lines_q, frame_lines_d;

  logic             tick;
  logic             hs_rise;
  logic             vs_rise;
  logic             lock_upd;
  logic [CNT_W-1:0] v_meas;

  assign tick     = (div_q == DIV_LAST);
  assign hs_rise  = hs_in & ~hsync_q;
  assign vs_rise  = hs_rise & vs_in & ~vsync_q;
  assign lock_upd = tick & vs_rise;
  assign v_meas   = sat_inc(v_cnt_q);

  always_comb begin
    div_d         = tick ? '0 : div_q + DIV_W'(1);
    ce_pix_d      = tick;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    if (tick) begin
      hsync_d = hs_in;
      if (hs_rise) begin
        line_len_d = sat_inc(h_cnt_q);
        h_cnt_d    = '0;
        v_cnt_d    = v_meas;
        vsync_d    = vs_in;
        if (vs_rise) begin
          v_cnt_d       = '0;
          frame_lines_d = v_meas;
        end
      end else begin
        h_cnt_d = sat_inc(h_cnt_q);
      end
      // blank follows the counter values being loaded this tick
      hblank_d = in_win(h_cnt_d,
                        bound(CNT_W'(HB_START), $signed(h_shift)),
                        bound(CNT_W'(HB_END), $signed(h_shift)));
      vblank_d = in_win(v_cnt_d,
                        bound(CNT_W'(VB_START), $signed(v_shift)),
                        bound(CNT_W'(VB_END), $signed(v_shift)));
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      ce_pix_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
    end else begin
      div_q         <= div_d;
      ce_pix_q      <= ce_pix_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
    end
  end

  bally_lock_tracker #(
    .CNT_W       (CNT_W),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_lock (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .upd      (lock_upd),
    .v_sat    (v_cnt_q == CNT_MAX),
    .new_len  (v_meas),
    .prev_len (frame_lines_q),
    .locked   (locked)
  );

  assign ce_pix      = ce_pix_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_bally_video_timing.sv
// Scoreboard bench for bally_video_timing with a small timing setup:
// 24-tick lines, 12/13-line frames, CNT_W=8 so saturation is reachable.
module tb_bally_video_timing;

  localparam int CE_DIV = 8;
  localparam int CW     = 8;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          hs_in   = 1'b0;
  logic          vs_in   = 1'b0;
  logic [5:0]    h_shift = '0;
  logic [5:0]    v_shift = '0;
  logic          ce_pix, hsync, vsync, hblank, vblank, locked;
  logic [CW-1:0] h_cnt, v_cnt, line_len, frame_lines;

  bally_video_timing #(
    .CE_DIV      (CE_DIV),
    .CNT_W       (CW),
    .HB_START    (20),
    .HB_END      (6),
    .VB_START    (10),
    .VB_END      (2),
    .LOCK_FRAMES (4)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .h_shift     (h_shift),
    .v_shift     (v_shift),
    .ce_pix      (ce_pix),
    .hsync       (hsync),
    .vsync       (vsync),
    .hblank      (hblank),
    .vblank      (vblank),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .locked      (locked)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int   h;
    int   v;
    logic hb;
    logic vb;
    logic hs;
    logic vs;
    logic lk;
    int   fl;
    logic chk_ll;
    int   ll;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // hand-derived windows: HB 20..6 (wrap), VB 10..2 (wrap), per shift
  function automatic logic exp_hb(input int h, input int sh);
    case (sh)
      0:       return (h >= 20) || (h < 6);
      -4:      return (h >= 16) || (h < 2);
      -10:     return (h >= 10);
      5:       return (h >= 25) || (h < 11);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic exp_vb(input int v, input int sh);
    case (sh)
      0:       return (v >= 10) || (v < 2);
      3:       return (v >= 13) || (v < 5);
      default: return 1'b1;
    endcase
  endfunction

  // monitor: every pixel strobe with a pending expectation is checked
  always @(negedge clk_sys) begin
    if (ce_pix && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("h_cnt", int'(h_cnt), e.h);
      check("v_cnt", int'(v_cnt), e.v);
      check("hblank", int'(hblank), int'(e.hb));
      check("vblank", int'(vblank), int'(e.vb));
      check("hsync", int'(hsync), int'(e.hs));
      check("vsync", int'(vsync), int'(e.vs));
      check("locked", int'(locked), int'(e.lk));
      check("frame_lines", int'(frame_lines), e.fl);
      if (e.chk_ll) check("line_len", int'(line_len), e.ll);
    end
  end

  // measurements per vs rise: first rise sees v_cnt=0, frame 5 is 13 lines
  int   fl_tab [1:10] = '{1, 12, 12, 12, 12, 12, 13, 12, 12, 12};
  logic lk_tab [1:10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

  int   l        = 0;
  logic ev       = 1'b0;
  int   prev_len = -1;
  int   k        = 0;
  int   exp_fl   = 0;
  logic exp_lk   = 1'b0;
  int   exp_ll   = 0;
  logic ll_known = 1'b0;

  task automatic wait_tick(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 4 * CE_DIV; n++) begin
      @(posedge clk_sys);
      #1;
      if (ce_pix) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ce_pix_timeout", 0, 1);
  endtask

  task automatic run_line(input int len, input logic vsl,
                          input int hsh, input int hmid, input int vsh);
    for (int i = 0; i < len; i++) begin
      int   sh;
      logic ok;
      exp_t e;
      sh      = (i >= 12) ? hmid : hsh;
      hs_in   = (i < 2);
      vs_in   = vsl;
      h_shift = 6'(sh);
      v_shift = 6'(vsh);
      wait_tick(ok);
      if (i == 0) begin
        if (vsl && !ev) begin
          l = 0;
          if (k < 10) k++;
          exp_fl = fl_tab[k];
          exp_lk = lk_tab[k];
        end else begin
          l++;
        end
        ev = vsl;
        if (prev_len >= 0) begin
          exp_ll   = (prev_len > 255) ? 255 : prev_len;
          ll_known = 1'b1;
        end
        prev_len = len;
      end
      e.h      = (i > 255) ? 255 : i;
      e.v      = l;
      e.hb     = exp_hb(e.h, sh);
      e.vb     = exp_vb(l, vsh);
      e.hs     = (i < 2);
      e.vs     = ev;
      e.lk     = exp_lk;
      e.fl     = exp_fl;
      e.chk_ll = ll_known;
      e.ll     = exp_ll;
      if (ok) q.push_back(e);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ce_pix"}, int'(ce_pix), 0);
    check({tag, "_hsync"}, int'(hsync), 0);
    check({tag, "_vsync"}, int'(vsync), 0);
    check({tag, "_hblank"}, int'(hblank), 1);
    check({tag, "_vblank"}, int'(vblank), 1);
    check({tag, "_h_cnt"}, int'(h_cnt), 0);
    check({tag, "_v_cnt"}, int'(v_cnt), 0);
    check({tag, "_line_len"}, int'(line_len), 0);
    check({tag, "_frame_lines"}, int'(frame_lines), 0);
    check({tag, "_locked"}, int'(locked), 0);
  endtask

  initial begin
    int n;
    int hi;
    repeat (3) @(posedge clk_sys);
    #1;
    check_reset_state("rst0");

    // divider: first strobe CE_DIV cycles after release, then 1 in CE_DIV
    @(negedge clk_sys);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 4 * CE_DIV; i++) begin
      @(negedge clk_sys);
      n++;
      if (ce_pix) break;
    end
    check("first_ce_cycle", n, CE_DIV);
    hi = 0;
    for (int i = 0; i < 8 * CE_DIV; i++) begin
      @(negedge clk_sys);
      if (ce_pix) hi++;
    end
    check("ce_pix_count", hi, 8);

    // frames 0..8; frame 7 shifts hblank, frame 8 shifts mid-line and vblank
    for (int f = 0; f < 9; f++) begin
      int len;
      len = (f == 5) ? 13 : 12;
      for (int ln = 0; ln < len; ln++) begin
        if (f == 7)      run_line(24, ln < 2, -4, -4, 0);
        else if (f == 8) run_line(24, ln < 2, 5, -10, 3);
        else             run_line(24, ln < 2, 0, 0, 0);
      end
    end
    run_line(24, 1'b1, 0, 0, 0);
    run_line(300, 1'b1, 0, 0, 0);
    run_line(24, 1'b0, 0, 0, 0);

    @(negedge clk_sys);
    #1;
    check("queue_drained", q.size(), 0);

    // asynchronous reset mid-frame, away from any clock edge
    @(posedge clk_sys);
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("rst_mid");
    repeat (2) @(posedge clk_sys);
    #1;
    check_reset_state("rst_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
